ixc_mev_clk_hold_ctrl: RTL

//  Initiator side of the mevClk hold/active/busy handshake. Takes a host hold

---
 rtl/ixc_mev_clk_hold_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ixc_mev_clk_hold_ctrl.sv
// Initiator side of the mevClk hold/active/busy handshake: freezes N event-clock
// generators plus the global clock hold, acks once enabled generators are quiet.
module ixc_mev_clk_hold_ctrl #(
  parameter int N_CLK       = 4,
  parameter int QUIET_CYC   = 2,
  parameter int TIMEOUT     = 256,
  parameter int RELEASE_CYC = 2
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             hold_req,
  input  logic [N_CLK-1:0] clk_en,
  input  logic [N_CLK-1:0] active,
  input  logic [N_CLK-1:0] busy,
  input  logic             to_clr,
  output logic [N_CLK-1:0] hold,
  output logic             b_clk_hold,
  output logic             hold_ack,
  output logic             timeout,
  output logic [1:0]       state_o
);

  localparam int QW = $clog2(QUIET_CYC + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = $clog2(RELEASE_CYC + 1);

  localparam logic [QW-1:0] Q_LAST = QW'(QUIET_CYC - 1);
  localparam logic [QW-1:0] Q_MAX  = QW'(QUIET_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};
  localparam logic [RW-1:0] R_LAST = RW'(RELEASE_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DRAIN   = 2'b01,
    ST_HOLD    = 2'b10,
    ST_RELEASE = 2'b11
  } state_t;

  state_t           state, state_d;
  logic [N_CLK-1:0] hold_d;
  logic             b_clk_hold_d, hold_ack_d, timeout_d;
  logic [QW-1:0]    quiet_cnt, quiet_cnt_d;
  logic [TW-1:0]    to_cnt, to_cnt_d;
  logic [RW-1:0]    rel_cnt, rel_cnt_d;
  logic             quiet;

  // Disabled generators never block the quiet check.
  assign quiet   = ~|((active | busy) & clk_en);
  assign state_o = state;

  // NOTE: combinational next-state logic uses blocking '=' with every target
  // defaulted first so no latch is inferred; the register process uses '<='.
  always_comb begin
    state_d      = state;
    hold_d       = hold;
    b_clk_hold_d = b_clk_hold;
    hold_ack_d   = hold_ack;
    timeout_d    = timeout & ~to_clr;
    quiet_cnt_d  = quiet_cnt;
    to_cnt_d     = to_cnt;
    rel_cnt_d    = rel_cnt;

    case (state)
      ST_RUN: begin
        if (hold_req) begin
          state_d      = ST_DRAIN;
          hold_d       = clk_en;
          b_clk_hold_d = 1'b1;
          quiet_cnt_d  = '0;
          to_cnt_d     = '0;
        end
      end

      ST_DRAIN: begin
        hold_d = clk_en;
        if (!hold_req) begin
          state_d    = ST_RELEASE;
          hold_d     = '0;
          hold_ack_d = 1'b0;
          rel_cnt_d  = '0;
        end else if (quiet && quiet_cnt == Q_LAST) begin
          state_d    = ST_HOLD;
          hold_ack_d = 1'b1;
        end else if ((TIMEOUT != 0) && to_cnt == T_LAST) begin
          // Forced ack; the flag set overrides a coincident to_clr.
          state_d    = ST_HOLD;
          hold_ack_d = 1'b1;
          timeout_d  = 1'b1;
        end else begin
          quiet_cnt_d = !quiet ? '0 :
                        (quiet_cnt == Q_MAX) ? quiet_cnt : quiet_cnt + QW'(1);
          to_cnt_d    = (to_cnt == T_MAX) ? to_cnt : to_cnt + TW'(1);
        end
      end

      ST_HOLD: begin
        hold_d     = clk_en;
        hold_ack_d = 1'b1;
        if (!hold_req) begin
          state_d    = ST_RELEASE;
          hold_d     = '0;
          hold_ack_d = 1'b0;
          rel_cnt_d  = '0;
        end
      end

      ST_RELEASE: begin
        // Global hold outlives the per-clock holds; hold_req is not looked at here.
        if (rel_cnt == R_LAST) begin
          state_d      = ST_RUN;
          b_clk_hold_d = 1'b0;
        end else begin
          rel_cnt_d = rel_cnt + RW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state      <= ST_RUN;
      hold       <= '0;
      b_clk_hold <= 1'b0;
      hold_ack   <= 1'b0;
      timeout    <= 1'b0;
      quiet_cnt  <= '0;
      to_cnt     <= '0;
      rel_cnt    <= '0;
    end else begin
      state      <= state_d;
      hold       <= hold_d;
      b_clk_hold <= b_clk_hold_d;
      hold_ack   <= hold_ack_d;
      timeout    <= timeout_d;
      quiet_cnt  <= quiet_cnt_d;
      to_cnt     <= to_cnt_d;
      rel_cnt    <= rel_cnt_d;
    end
  end

endmodule
